// File: rtl/btn_debounce_array_if.sv
// Button bundle between the raw pin side and the core side.
//   i_btn     : raw asynchronous pins, one per channel
//   o_btn     : debounced level, 1 = pressed
//   o_press   : one-cycle pulse when a press is accepted
//   o_release : one-cycle pulse when a release is accepted
//   o_long    : one-cycle pulse when a hold reaches the long-press time
//   o_repeat  : one-cycle auto-repeat pulse while the hold continues
// master = pin source / consumer of events, slave = the conditioner.
interface btn_debounce_array_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] i_btn;
  logic [CHANNELS-1:0] o_btn;
  logic [CHANNELS-1:0] o_press;
  logic [CHANNELS-1:0] o_release;
  logic [CHANNELS-1:0] o_long;
  logic [CHANNELS-1:0] o_repeat;

  modport master (
    output i_btn,
    input  o_btn, o_press, o_release, o_long, o_repeat
  );

  modport slave (
    input  i_btn,
    output o_btn, o_press, o_release, o_long, o_repeat
  );
endinterface

// File: rtl/btn_debounce_array.sv
// Multi-channel push-button conditioner: per channel a synchroniser, a
// time-qualified debounced level, press/release pulses, and long-press
// detection with optional auto-repeat. Channels are fully independent.
// Ports:
//   i_clk : single clock for all logic
//   i_rst : asynchronous active-high reset
//   bus   : btn_debounce_array_if.slave (raw pins in, level/events out)
// All outputs are registered.
module btn_debounce_array #(
  parameter int CHANNELS       = 4,
  parameter int CLK_PERIOD_NS  = 20,
  parameter int STABLE_TIME_MS = 5,
  parameter int LONG_PRESS_MS  = 1000,
  parameter int REPEAT_MS      = 200,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  btn_debounce_array_if.slave  bus
);

  // Milliseconds to whole clock cycles, never below one cycle.
  function automatic longint cyc_of(input longint ms);
    longint c;
    c = (ms * 64'sd1_000_000) / longint'(CLK_PERIOD_NS);
    return (c < 64'sd1) ? 64'sd1 : c;
  endfunction

  localparam longint STABLE_CYC = cyc_of(longint'(STABLE_TIME_MS));
  localparam longint LONG_CYC   = cyc_of(longint'(LONG_PRESS_MS));
  localparam longint REPEAT_CYC = cyc_of(longint'(REPEAT_MS));
  localparam bit     REPEAT_EN  = (REPEAT_MS != 0);

  localparam int STB_W = $clog2(STABLE_CYC + 1);
  localparam int HLD_W = $clog2(LONG_CYC + REPEAT_CYC + 1);

  localparam logic [STB_W-1:0] STB_LAST   = STB_W'(STABLE_CYC - 1);
  localparam logic [HLD_W-1:0] HLD_LONG   = HLD_W'(LONG_CYC);
  localparam logic [HLD_W-1:0] HLD_TOP    = HLD_W'(LONG_CYC + REPEAT_CYC);
  localparam logic [HLD_W-1:0] HLD_RELOAD = HLD_W'(LONG_CYC + 1);

  logic [CHANNELS-1:0] w_btn;
  logic [CHANNELS-1:0] w_press;
  logic [CHANNELS-1:0] w_release;
  logic [CHANNELS-1:0] w_long;
  logic [CHANNELS-1:0] w_repeat;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [STB_W-1:0]       r_stb;
    logic [HLD_W-1:0]       r_hold;
    logic                   r_btn;
    logic                   r_press;
    logic                   r_release;
    logic                   r_long;
    logic                   r_repeat;

    logic                   w_s;
    logic                   w_diff;
    logic                   w_toggle;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_hold_inc;
    logic [HLD_W-1:0]       w_hold_nxt;

    // Synchronised sample, normalised so that 1 means pressed.
    assign w_s      = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;
    assign w_diff   = w_s ^ r_btn;
    // The increment that would bring the counter to STABLE_CYC is replaced
    // by the level toggle itself.
    assign w_toggle = w_diff && (r_stb == STB_LAST);
    assign w_rise   = w_toggle && !r_btn;
    assign w_fall   = w_toggle && r_btn;

    // Hold counter: zero while released and in the press cycle, cleared by
    // the release edge, wraps back to LONG+1 after each repeat point, or
    // parks at LONG when repeat is disabled.
    always_comb begin
      w_hold_nxt = '0;
      w_hold_inc = 1'b0;
      if (r_btn && !w_fall) begin
        if (REPEAT_EN && (r_hold == HLD_TOP)) begin
          w_hold_nxt = HLD_RELOAD;
        end else if (!REPEAT_EN && (r_hold == HLD_LONG)) begin
          w_hold_nxt = r_hold;
        end else begin
          w_hold_nxt = r_hold + HLD_W'(1);
          w_hold_inc = 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        // Preset to the released pin level so reset never looks like a press.
        r_sync    <= {SYNC_STAGES{ACTIVE_LOW}};
        r_stb     <= '0;
        r_hold    <= '0;
        r_btn     <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        // Stage: synchroniser
        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_btn[g]};

        // Stage: stability qualification
        if (!w_diff || w_toggle) begin
          r_stb <= '0;
        end else begin
          r_stb <= r_stb + STB_W'(1);
        end
        r_btn     <= r_btn ^ w_toggle;
        r_press   <= w_rise;
        r_release <= w_fall;

        // Stage: hold timing
        r_hold   <= w_hold_nxt;
        r_long   <= w_hold_inc && (w_hold_nxt == HLD_LONG);
        r_repeat <= REPEAT_EN && (w_hold_nxt == HLD_TOP);
      end
    end

    assign w_btn[g]     = r_btn;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;
    assign w_long[g]    = r_long;
    assign w_repeat[g]  = r_repeat;
  end

  assign bus.o_btn     = w_btn;
  assign bus.o_press   = w_press;
  assign bus.o_release = w_release;
  assign bus.o_long    = w_long;
  assign bus.o_repeat  = w_repeat;

endmodule

// File: tb/tb_btn_debounce_array.sv
// Bench for btn_debounce_array: two instances (active-low with repeat,
// active-high without repeat) driven by directed scenarios and random pin
// activity, checked every cycle against a time-based behavioural model.
module tb_btn_debounce_array;
  localparam int NC  = 4;
  localparam int SS  = 2;
  localparam int STB = 5;
  localparam int LNG = 20;
  localparam int REP = 8;

  logic clk;
  logic rst;
  logic [NC-1:0] pin [2];

  int errors = 0;
  int checks = 0;

  btn_debounce_array_if #(.CHANNELS(NC)) ifa ();
  btn_debounce_array_if #(.CHANNELS(NC)) ifb ();

  assign ifa.i_btn = pin[0];
  assign ifb.i_btn = pin[1];

  btn_debounce_array #(
    .CHANNELS(NC), .CLK_PERIOD_NS(1_000_000), .STABLE_TIME_MS(5),
    .LONG_PRESS_MS(20), .REPEAT_MS(8), .ACTIVE_LOW(1'b1), .SYNC_STAGES(SS)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(ifa.slave)
  );

  btn_debounce_array #(
    .CHANNELS(NC), .CLK_PERIOD_NS(1_000_000), .STABLE_TIME_MS(5),
    .LONG_PRESS_MS(20), .REPEAT_MS(0), .ACTIVE_LOW(1'b0), .SYNC_STAGES(SS)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit al  [2] = '{1'b1, 1'b0};
  bit ren [2] = '{1'b1, 1'b0};
  bit pipe [2][NC][$];
  int streak [2][NC];
  int held   [2][NC];
  logic [NC-1:0] e_btn [2];
  logic [NC-1:0] e_press [2];
  logic [NC-1:0] e_rel [2];
  logic [NC-1:0] e_long [2];
  logic [NC-1:0] e_rep [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      e_btn[d] = '0; e_press[d] = '0; e_rel[d] = '0; e_long[d] = '0; e_rep[d] = '0;
      for (int c = 0; c < NC; c++) begin
        pipe[d][c].delete();
        for (int k = 0; k < SS; k++) pipe[d][c].push_back(1'b0);
        streak[d][c] = 0;
        held[d][c]   = 0;
      end
    end
  endfunction

  // The qualifier sees the pressed-sense pin value from SS edges ago; a level
  // is accepted once it has been seen STB times in a row; events are timed
  // by the number of cycles elapsed since the press was reported.
  function automatic void model_step();
    bit seen;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        seen = pipe[d][c].pop_front();
        pipe[d][c].push_back(bit'(pin[d][c] ^ al[d]));
        e_press[d][c] = 1'b0; e_rel[d][c] = 1'b0;
        e_long[d][c]  = 1'b0; e_rep[d][c] = 1'b0;
        if (seen != e_btn[d][c]) streak[d][c]++;
        else streak[d][c] = 0;
        if (streak[d][c] == STB) begin
          streak[d][c] = 0;
          e_btn[d][c] = ~e_btn[d][c];
          if (e_btn[d][c]) begin
            e_press[d][c] = 1'b1;
            held[d][c] = 0;
          end else begin
            e_rel[d][c] = 1'b1;
          end
        end else if (e_btn[d][c]) begin
          held[d][c]++;
          e_long[d][c] = (held[d][c] == LNG);
          e_rep[d][c]  = ren[d] && (held[d][c] > LNG) && (((held[d][c] - LNG) % REP) == 0);
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  task automatic cmp(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // Single compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    cmp("A o_btn",     ifa.o_btn,     e_btn[0]);
    cmp("A o_press",   ifa.o_press,   e_press[0]);
    cmp("A o_release", ifa.o_release, e_rel[0]);
    cmp("A o_long",    ifa.o_long,    e_long[0]);
    cmp("A o_repeat",  ifa.o_repeat,  e_rep[0]);
    cmp("B o_btn",     ifb.o_btn,     e_btn[1]);
    cmp("B o_press",   ifb.o_press,   e_press[1]);
    cmp("B o_release", ifb.o_release, e_rel[1]);
    cmp("B o_long",    ifb.o_long,    e_long[1]);
    cmp("B o_repeat",  ifb.o_repeat,  e_rep[1]);
  end

  // ---------------- stimulus ----------------
  task automatic ed(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  function automatic logic [NC-1:0] any_a();
    return ifa.o_btn | ifa.o_press | ifa.o_release | ifa.o_long | ifa.o_repeat;
  endfunction

  initial begin
    int cnt, at, nl, la, nev;
    int rq [$];
    int cd [2][NC];

    pin[0] = 4'hF;
    pin[1] = 4'h0;
    rst = 1'b1;

    // 1: reset, then idle with all pins released
    ed(3);
    chk("s1 reset outputs A", int'(any_a()), 0);
    chk("s1 reset o_btn B", int'(ifb.o_btn), 0);
    neg(); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      ed(1);
      if (any_a() != '0) cnt++;
    end
    chk("s1 quiet cycles", cnt, 0);

    // 2: single press on channel 0
    neg(); pin[0][0] = 1'b0;
    ed(6);
    chk("s2 press early", int'(ifa.o_press[0]), 0);
    ed(1);
    chk("s2 press at edge6", int'(ifa.o_press), 1);
    chk("s2 model press", int'(e_press[0]), 1);
    chk("s2 level", int'(ifa.o_btn), 1);
    ed(1);
    chk("s2 press one cycle", int'(ifa.o_press), 0);
    chk("s2 level held", int'(ifa.o_btn), 1);

    // 3: short low glitches on channel 1, then a real press
    cnt = 0;
    for (int r = 0; r < 10; r++) begin
      neg(); pin[0][1] = 1'b0;
      for (int i = 0; i < 4; i++) begin ed(1); cnt += int'(ifa.o_press[1]); end
      neg(); pin[0][1] = 1'b1;
      for (int i = 0; i < 2; i++) begin ed(1); cnt += int'(ifa.o_press[1]); end
    end
    chk("s3 glitch presses", cnt, 0);
    neg(); pin[0][1] = 1'b0;
    cnt = 0; at = -1;
    for (int i = 1; i <= 10; i++) begin
      ed(1);
      if (ifa.o_press[1]) begin cnt++; at = i; end
    end
    chk("s3 press count", cnt, 1);
    chk("s3 press edge", at, 7);

    // 4: long press and auto-repeat on channel 2
    neg(); pin[0][2] = 1'b0;
    ed(7);
    chk("s4 press", int'(ifa.o_press[2]), 1);
    nl = 0; la = -1; rq.delete();
    for (int k = 1; k <= 60; k++) begin
      ed(1);
      if (ifa.o_long[2]) begin nl++; la = k; end
      if (ifa.o_repeat[2]) rq.push_back(k);
    end
    chk("s4 long count", nl, 1);
    chk("s4 long offset", la, 20);
    chk("s4 model long offset", (held[0][2] - 60 + 20), 20);
    chk("s4 repeat count", rq.size(), 5);
    if (rq.size() == 5) begin
      chk("s4 repeat1", rq[0], 28);
      chk("s4 repeat2", rq[1], 36);
      chk("s4 repeat5", rq[4], 60);
    end
    neg(); pin[0][2] = 1'b1;
    cnt = 0; at = -1; nev = 0;
    for (int i = 1; i <= 15; i++) begin
      ed(1);
      if (ifa.o_release[2]) begin cnt++; at = i; end
      nev += int'(ifa.o_long[2]) + int'(ifa.o_repeat[2]);
    end
    chk("s4 release count", cnt, 1);
    chk("s4 release edge", at, 7);
    chk("s4 events after release", nev, 0);

    // 5: simultaneous press on 0 and 3, reset during the hold
    neg(); pin[0] = 4'hF;
    ed(15);
    chk("s5 all released", int'(ifa.o_btn), 0);
    neg(); pin[0] = 4'b0110;
    ed(7);
    chk("s5 dual press", int'(ifa.o_press), 9);
    chk("s5 model dual press", int'(e_press[0]), 9);
    ed(15);
    #2 rst = 1'b1;
    #1;
    chk("s5 reset immediate A", int'(any_a()), 0);
    chk("s5 reset immediate B", int'(ifb.o_btn), 0);
    neg(); rst = 1'b0;
    ed(6);
    chk("s5 repress early", int'(ifa.o_press), 0);
    ed(1);
    chk("s5 repress", int'(ifa.o_press), 9);
    neg(); pin[0] = 4'hF;
    ed(15);

    // 6: active-high instance without repeat
    neg(); pin[1][2] = 1'b1;
    ed(7);
    chk("s6 press", int'(ifb.o_press), 4);
    nl = 0; la = -1; cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      ed(1);
      if (ifb.o_long[2]) begin nl++; la = k; end
      cnt += int'(ifb.o_repeat[2]);
    end
    chk("s6 long count", nl, 1);
    chk("s6 long offset", la, 20);
    chk("s6 repeat count", cnt, 0);
    neg(); pin[1][2] = 1'b0;
    cnt = 0; nev = 0;
    for (int i = 1; i <= 15; i++) begin
      ed(1);
      cnt += int'(ifb.o_release[2]);
      nev += int'(ifb.o_long[2]) + int'(ifb.o_repeat[2]);
    end
    chk("s6 release count", cnt, 1);
    chk("s6 events after release", nev, 0);

    // Random pin activity on both instances with occasional reset pulses
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC; c++) cd[d][c] = int'($urandom_range(1, 40));
    for (int i = 0; i < 4000; i++) begin
      neg();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 999) == 0) rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NC; c++) begin
          if (cd[d][c] == 0) begin
            pin[d][c] = ~pin[d][c];
            cd[d][c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 7))
                                                   : int'($urandom_range(8, 70));
          end else begin
            cd[d][c]--;
          end
        end
      end
    end
    neg(); rst = 1'b0;
    ed(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_debounce_array.md
# btn_debounce_array

Multi-channel push-button conditioner for the board I/O path, between the raw `KEY`/switch pins and the `i_io_btn` input of the core. Per channel it provides:

- metastability synchronisation
- a time-qualified debounced level
- one-cycle press and release pulses
- long-press detection with optional auto-repeat

It generalises the per-key debouncer to N channels, selectable input polarity and hold-time events.

## Interface

Parameters:
- `CHANNELS`, 4, number of independent button channels (≥1)
- `CLK_PERIOD_NS`, 20, clock period in ns; 20 corresponds to the 50 MHz clock
- `STABLE_TIME_MS`, 5, time a new level must persist before it is accepted
- `LONG_PRESS_MS`, 1000, hold time before the long-press event fires
- `REPEAT_MS`, 200, auto-repeat period after a long press; 0 disables repeat
- `ACTIVE_LOW`, 1, 1 = raw pin reads 0 when pressed; 0 = pin reads 1 when pressed
- `SYNC_STAGES`, 2, synchroniser flop depth (≥2)

Derived constants are integer cycle counts, each clamped to at least 1:
- `STABLE_CYC` = STABLE_TIME_MS·1e6/CLK_PERIOD_NS
- `LONG_CYC` = LONG_PRESS_MS·1e6/CLK_PERIOD_NS
- `REPEAT_CYC` = REPEAT_MS·1e6/CLK_PERIOD_NS

Ports:
- `i_clk`, in, 1, single clock for all logic
- `i_rst`, in, 1, reset; asynchronous, active-high
- `i_btn`, in, CHANNELS, raw asynchronous button pins
- `o_btn`, out, CHANNELS, debounced level; 1 = pressed, regardless of ACTIVE_LOW
- `o_press`, out, CHANNELS, one-cycle pulse on a debounced press
- `o_release`, out, CHANNELS, one-cycle pulse on a debounced release
- `o_long`, out, CHANNELS, one-cycle pulse when a hold reaches LONG_CYC
- `o_repeat`, out, CHANNELS, one-cycle pulse every REPEAT_CYC after `o_long` while still held

## Operation

- Channels are fully independent. Each channel has:
  - a synchroniser chain
  - a stability counter, width clog2(STABLE_CYC+1)
  - a hold counter, width clog2(LONG_CYC+REPEAT_CYC+1)
- Synchroniser: SYNC_STAGES flops.
  - The last stage output is XORed with ACTIVE_LOW to produce `s`, where 1 = pressed.
- Stability counter:
  - If `s` equals `o_btn`, the counter clears to 0.
  - Otherwise the counter increments.
  - On the cycle the counter would reach STABLE_CYC, the following happen at that edge:
    - `o_btn` toggles.
    - The counter clears.
    - `o_press` (0→1) or `o_release` (1→0) is registered high for exactly one cycle.
  - Any sample where `s` equals `o_btn` before that point restarts qualification, so glitches shorter than STABLE_CYC cycles are invisible.
- Hold counter:
  - Held at 0 while `o_btn`=0.
  - Increments every cycle while `o_btn`=1, starting from 0 in the `o_press` cycle.
  - When the count equals LONG_CYC:
    - `o_long` pulses.
    - If REPEAT_CYC>0 (REPEAT_MS≠0), the counter continues.
    - If REPEAT_MS=0, the counter saturates and `o_repeat` never fires.
  - When the count equals LONG_CYC+REPEAT_CYC:
    - `o_repeat` pulses.
    - The counter reloads to LONG_CYC+1 on the next edge, giving a REPEAT_CYC-periodic repeat.
  - Release, in the `o_release` cycle, clears the counter. No `o_long` or `o_repeat` fires in or after that cycle.
- Event exclusivity:
  - `o_press` and `o_release` are mutually exclusive per channel.
  - `o_long` and `o_repeat` are mutually exclusive per channel.
  - A channel cannot emit `o_long` in its `o_press` cycle.
- All outputs are registered; there is no combinational path from `i_btn`.

## Timing

- Reset (`i_rst`=1, asynchronous):
  - All synchroniser flops go to the released pin level (ACTIVE_LOW ? 1 : 0), so no false press occurs after reset.
  - Both counters go to 0.
  - `o_btn`, `o_press`, `o_release`, `o_long` and `o_repeat` all go to 0.
- Reset release: the first edge after deassertion performs normal operation. Reset asserted mid-qualification or mid-hold discards all progress.
- Press latency: a raw level change first sampled at edge 0 produces `o_btn`/`o_press` high after edge SYNC_STAGES+STABLE_CYC−1, i.e. observable in that cycle. Release has the same latency.
- Long-press timing: `o_long` is LONG_CYC cycles after the `o_press` cycle. The k-th `o_repeat` is LONG_CYC+k·REPEAT_CYC cycles after `o_press`.
- Simultaneous events on different channels are all reported in the same cycle.

## Test plan

Default bench parameters: CHANNELS=4, CLK_PERIOD_NS=1_000_000, STABLE_TIME_MS=5, LONG_PRESS_MS=20, REPEAT_MS=8, ACTIVE_LOW=1, SYNC_STAGES=2. This gives STABLE_CYC=5, LONG_CYC=20, REPEAT_CYC=8.

1. Reset with `i_btn`=4'hF, then release reset and hold for 50 cycles → all outputs remain 0 throughout.
2. `i_btn[0]` driven 1→0 and held → `o_press[0]` is a single pulse 6 cycles after the first sampling edge; `o_btn[0]`=1 from then on; no other channel changes.
3. `i_btn[1]` low-glitches of 4 cycles, repeated 10 times with 2-cycle high gaps, then held low → no `o_press[1]` during the glitches; exactly one `o_press[1]` once the line has been stable for 5 cycles.
4. `i_btn[2]` held low for 60 cycles after the press → `o_long[2]` 20 cycles after `o_press[2]`; `o_repeat[2]` at +28, +36, +44, +52, … cycles. On release, exactly one `o_release[2]` and no further events.
5. Channels 0 and 3 pressed on the same edge → `o_press`=4'b1001 in a single cycle. Then `i_rst` is pulsed during channel 3's hold at cycle 15 → all outputs go to 0 immediately. After reset release, with both still held low, `o_press` fires again 6 cycles later.
6. Re-run scenario 4 with REPEAT_MS=0 and ACTIVE_LOW=0, using inverted stimulus → `o_long` fires once and `o_repeat` never asserts.
